// File: rtl/motor_command_writer.sv
// CPU-writable motor command block: per-axis direction enables plus a tick-timed run FSM.
// Movement outputs are live only while a timed run is in progress.
module motor_command_writer #(
    parameter int TICK_DIV  = 50000,
    parameter int CMD_ADDR  = 20006,
    parameter int DUR_ADDR  = 20008,
    parameter int CTRL_ADDR = 20009
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEnable,
    input  logic [14:0] addrA,
    input  logic [15:0] dinA,
    output logic [5:0]  movementOut,
    output logic        running,
    output logic        timesUp,
    output logic [15:0] statusWord,
    output logic [1:0]  stateDbg
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [14:0] CMD_A  = 15'(CMD_ADDR);
    localparam logic [14:0] DUR_A  = 15'(DUR_ADDR);
    localparam logic [14:0] CTRL_A = 15'(CTRL_ADDR);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [1:0]    state;
    logic [5:0]    enableReg;
    logic [15:0]   durationReg;
    logic [15:0]   remaining;
    logic [PW-1:0] prescaler;

    logic       wrCmd, wrDur, wrCtrl;
    logic       startReq, abortReq, tick;
    logic [5:0] cmdEnable;

    assign wrCmd    = writeEnable && (addrA == CMD_A);
    assign wrDur    = writeEnable && (addrA == DUR_A);
    assign wrCtrl   = writeEnable && (addrA == CTRL_A);
    assign abortReq = wrCtrl && dinA[1];
    assign startReq = wrCtrl && dinA[0] && !dinA[1];
    assign tick     = (prescaler == PRE_MAX);

    // One-hot value sets a bit (and clears its opposing partner); 7-bit one-cold value clears it.
    always_comb begin
        cmdEnable = enableReg;
        for (int i = 0; i < 6; i++) begin
            if (dinA == (16'd1 << i)) begin
                cmdEnable[i]     = 1'b1;
                cmdEnable[i ^ 1] = 1'b0;
            end else if (dinA == (16'h007f & ~(16'd1 << i))) begin
                cmdEnable[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            enableReg   <= 6'd0;
            durationReg <= 16'd0;
            remaining   <= 16'd0;
            prescaler   <= '0;
        end else begin
            if (wrCmd) begin
                enableReg <= cmdEnable;
            end
            case (state)
                IDLE: begin
                    if (wrDur) begin
                        durationReg <= dinA;
                    end
                    if (abortReq) begin
                        enableReg <= 6'd0;
                    end else if (startReq) begin
                        if (durationReg != 16'd0) begin
                            state     <= RUN;
                            remaining <= durationReg;
                            prescaler <= '0;
                        end else begin
                            state     <= DONE;
                            enableReg <= 6'd0;
                        end
                    end
                end
                RUN: begin
                    if (abortReq) begin
                        state     <= IDLE;
                        enableReg <= 6'd0;
                        prescaler <= '0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + 1'b1;
                        if (tick) begin
                            remaining <= remaining - 16'd1;
                            // Clearing on DONE entry keeps statusWord at zero during the timesUp pulse.
                            if (remaining == 16'd1) begin
                                state     <= DONE;
                                enableReg <= 6'd0;
                            end
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    enableReg <= 6'd0;
                end
                default: begin
                    state     <= IDLE;
                    enableReg <= 6'd0;
                end
            endcase
        end
    end

    assign running     = (state == RUN);
    assign timesUp     = (state == DONE);
    assign movementOut = running ? enableReg : 6'd0;
    assign statusWord  = {running, 9'd0, enableReg};
    assign stateDbg    = state;

endmodule

// File: tb/tb_motor_command_writer.sv
// Scoreboard bench for motor_command_writer with TICK_DIV=4: expected per-cycle
// {timesUp, running, movementOut} values are queued at stimulus time and popped each negedge.
module tb_motor_command_writer;

    localparam int TICK_DIV  = 4;
    localparam int CMD_ADDR  = 20006;
    localparam int DUR_ADDR  = 20008;
    localparam int CTRL_ADDR = 20009;

    logic        clk;
    logic        reset;
    logic        writeEnable;
    logic [14:0] addrA;
    logic [15:0] dinA;
    logic [5:0]  movementOut;
    logic        running;
    logic        timesUp;
    logic [15:0] statusWord;
    logic [1:0]  stateDbg;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    motor_command_writer #(
        .TICK_DIV (TICK_DIV),
        .CMD_ADDR (CMD_ADDR),
        .DUR_ADDR (DUR_ADDR),
        .CTRL_ADDR(CTRL_ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .writeEnable(writeEnable),
        .addrA      (addrA),
        .dinA       (dinA),
        .movementOut(movementOut),
        .running    (running),
        .timesUp    (timesUp),
        .statusWord (statusWord),
        .stateDbg   (stateDbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write presented after one edge, accepted on the following edge; returns 1ns after acceptance.
    task automatic doWrite(input int addr, input int data);
        @(posedge clk);
        #1;
        writeEnable = 1'b1;
        addrA       = 15'(addr);
        dinA        = 16'(data);
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        addrA       = 15'd0;
        dinA        = 16'd0;
    endtask

    task automatic pushN(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) exp_q.push_back(val);
    endtask

    task automatic drainQ(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (exp_q.size() > 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check("cycle_out", {timesUp, running, movementOut}, e);
        end
    end

    initial begin
        writeEnable = 1'b0;
        addrA       = 15'd0;
        dinA        = 16'd0;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out", {timesUp, running, movementOut}, 8'h00);
        check("rst_status", statusWord, 16'h0000);
        check("rst_state", stateDbg, 2'd0);
        reset = 1'b1;

        // Timed run: X right for 3 ticks of 4 clocks
        doWrite(CMD_ADDR, 16);
        doWrite(DUR_ADDR, 3);
        doWrite(CTRL_ADDR, 1);
        pushN(12, 8'b01_010000);
        pushN(1, 8'b10_000000);
        pushN(1, 8'b00_000000);
        drainQ(40);
        check("run_end_status", statusWord, 16'h0000);

        // Command encoding and opposing-pair exclusion
        doWrite(CMD_ADDR, 1);
        check("cmd_set0", statusWord, 16'h0001);
        doWrite(CMD_ADDR, 2);
        check("cmd_pair01", statusWord, 16'h0002);
        doWrite(CMD_ADDR, 125);
        check("cmd_clr1", statusWord, 16'h0000);
        doWrite(CMD_ADDR, 8);
        doWrite(CMD_ADDR, 7);
        check("cmd_ignore", statusWord, 16'h0008);
        doWrite(CMD_ADDR, 4);
        check("cmd_pair23", statusWord, 16'h0004);
        doWrite(CMD_ADDR, 32);
        doWrite(CMD_ADDR, 16);
        check("cmd_pair45", statusWord, 16'h0014);
        doWrite(CMD_ADDR, 111);
        check("cmd_clr4", statusWord, 16'h0004);
        doWrite(CMD_ADDR + 1, 1);
        check("cmd_wrong_addr", statusWord, 16'h0004);
        doWrite(CTRL_ADDR, 2);
        check("abort_idle", statusWord, 16'h0000);
        check("abort_idle_state", stateDbg, 2'd0);

        // Zero duration: straight to DONE
        doWrite(DUR_ADDR, 0);
        doWrite(CTRL_ADDR, 1);
        pushN(1, 8'b10_000000);
        pushN(2, 8'b00_000000);
        drainQ(10);

        // Abort mid-run; a duration write during the run must be ignored
        doWrite(CMD_ADDR, 32);
        doWrite(DUR_ADDR, 5);
        doWrite(CTRL_ADDR, 1);
        pushN(4, 8'b01_100000);
        pushN(3, 8'b00_000000);
        doWrite(DUR_ADDR, 9);
        doWrite(CTRL_ADDR, 3);
        drainQ(20);
        check("abort_run_status", statusWord, 16'h0000);
        doWrite(CMD_ADDR, 32);
        doWrite(CTRL_ADDR, 1);
        pushN(20, 8'b01_100000);
        pushN(1, 8'b10_000000);
        pushN(1, 8'b00_000000);
        drainQ(40);

        // Command change mid-run leaves the tick count alone
        doWrite(CMD_ADDR, 1);
        doWrite(DUR_ADDR, 3);
        doWrite(CTRL_ADDR, 1);
        pushN(2, 8'b01_000001);
        pushN(10, 8'b01_000101);
        pushN(1, 8'b10_000000);
        pushN(1, 8'b00_000000);
        doWrite(CMD_ADDR, 4);
        doWrite(CTRL_ADDR, 1);
        drainQ(40);

        // Asynchronous reset mid-run
        doWrite(CMD_ADDR, 8);
        doWrite(DUR_ADDR, 100);
        doWrite(CTRL_ADDR, 1);
        pushN(5, 8'b01_001000);
        drainQ(20);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out", {timesUp, running, movementOut}, 8'h00);
        check("async_rst_status", statusWord, 16'h0000);
        check("async_rst_state", stateDbg, 2'd0);
        pushN(3, 8'b00_000000);
        drainQ(10);
        @(negedge clk);
        reset = 1'b1;
        doWrite(CTRL_ADDR, 1);
        pushN(1, 8'b10_000000);
        pushN(1, 8'b00_000000);
        drainQ(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
